// File: rtl/mna_pkg.sv
// Shared types and header field layout for the master NA response scheduler.
package mna_pkg;

  // Scheduler FSM states; the encoding is fixed.
  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StBody = 2'd1,
    StResp = 2'd2
  } state_e;

  // Header flit field positions.
  localparam int unsigned READ_BIT = 2;
  localparam int unsigned RESP_LSB = 0;
  localparam int unsigned RESP_W   = 2;
  // Number of low header bits that carry information.
  localparam int unsigned HDR_W    = 3;

  // AXI response codes.
  localparam logic [1:0] OKAY   = 2'b00;
  localparam logic [1:0] SLVERR = 2'b10;

endpackage

// File: rtl/mna_rr_arbiter.sv
// Combinational round-robin arbiter: picks the first requester after last_grant, wrapping.
module mna_rr_arbiter #(
  parameter int unsigned N = 8
) (
  input  logic [N-1:0]         req,
  input  logic [$clog2(N)-1:0] last_grant,
  output logic [N-1:0]         grant,
  output logic [$clog2(N)-1:0] grant_idx
);

  localparam int unsigned IdxW = $clog2(N);

  int unsigned      pos;
  logic [IdxW-1:0]  idx;
  logic             found;

  // Scan from last_grant+1 around the ring; the first hit wins.
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    pos       = 0;
    idx       = '0;
    found     = 1'b0;
    for (int unsigned k = 0; k < N; k++) begin
      pos = (32'(last_grant) + 32'd1 + k) % N;
      idx = IdxW'(pos);
      if (!found && req[idx]) begin
        found      = 1'b1;
        grant[idx] = 1'b1;
        grant_idx  = idx;
      end
    end
  end

endmodule

// File: rtl/mna_response_scheduler.sv
// Response-path sequencer of the master NA: arbitrates VC buffers, pops header and
// body flits of one packet at a time and presents it on the AXI4-Lite R or B channel.
module mna_response_scheduler
  import mna_pkg::*;
#(
  parameter int unsigned NUM_VC = 8,
  parameter int unsigned DATA_W = 32
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NUM_VC-1:0]        vc_valid,
  input  logic [NUM_VC-1:0]        vc_head,
  input  logic [NUM_VC*DATA_W-1:0] vc_data,
  input  logic [NUM_VC-1:0]        vc_afull,
  output logic [NUM_VC-1:0]        vc_pop,
  output logic [DATA_W-1:0]        rdata,
  output logic [1:0]               rresp,
  output logic                     rvalid,
  input  logic                     rready,
  output logic [1:0]               bresp,
  output logic                     bvalid,
  input  logic                     bready,
  output logic [NUM_VC-1:0]        is_allocatable,
  output logic [NUM_VC-1:0]        is_on_off,
  output logic                     err_proto
);

  localparam int unsigned IdxW = $clog2(NUM_VC);

  state_e              state_q, state_d;
  logic [IdxW-1:0]     owner_q, owner_d;
  logic [IdxW-1:0]     last_grant_q, last_grant_d;
  logic                is_read_q, is_read_d;
  logic [RESP_W-1:0]   resp_q, resp_d;
  logic [DATA_W-1:0]   rdata_q, rdata_d;
  logic [1:0]          rresp_q, rresp_d;
  logic [1:0]          bresp_q, bresp_d;
  logic                rvalid_q, rvalid_d;
  logic                bvalid_q, bvalid_d;
  logic [NUM_VC-1:0]   alloc_q, alloc_d;
  logic [NUM_VC-1:0]   on_off_q;
  logic                err_q, err_d;

  logic [NUM_VC-1:0]   cand;
  logic [NUM_VC-1:0]   arb_grant;
  logic [IdxW-1:0]     arb_idx;
  logic [HDR_W-1:0]    win_hdr;
  logic [DATA_W-1:0]   owner_flit;
  logic                handshake;

  assign cand       = vc_valid & vc_head;
  assign win_hdr    = vc_data[arb_idx*DATA_W +: HDR_W];
  assign owner_flit = vc_data[owner_q*DATA_W +: DATA_W];
  assign handshake  = (rvalid_q && rready) || (bvalid_q && bready);

  mna_rr_arbiter #(
    .N(NUM_VC)
  ) u_arb (
    .req       (cand),
    .last_grant(last_grant_q),
    .grant     (arb_grant),
    .grant_idx (arb_idx)
  );

  // Next-state and pop decode.
  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    last_grant_d = last_grant_q;
    is_read_d    = is_read_q;
    resp_d       = resp_q;
    rdata_d      = rdata_q;
    rresp_d      = rresp_q;
    bresp_d      = bresp_q;
    rvalid_d     = rvalid_q;
    bvalid_d     = bvalid_q;
    alloc_d      = alloc_q;
    err_d        = err_q;
    vc_pop       = '0;
    unique case (state_q)
      StIdle: begin
        if (|cand) begin
          vc_pop           = arb_grant;
          owner_d          = arb_idx;
          is_read_d        = win_hdr[READ_BIT];
          resp_d           = win_hdr[RESP_LSB +: RESP_W];
          alloc_d[arb_idx] = 1'b0;
          state_d          = StBody;
        end
      end
      StBody: begin
        if (vc_valid[owner_q]) begin
          if (!vc_head[owner_q]) begin
            vc_pop[owner_q] = 1'b1;
            if (is_read_q) begin
              rdata_d  = owner_flit;
              rresp_d  = resp_q;
              rvalid_d = 1'b1;
            end else begin
              bresp_d  = resp_q;
              bvalid_d = 1'b1;
            end
            state_d = StResp;
          end else begin
            // Header where a body was due: drop the packet, leave the header for arbitration.
            err_d            = 1'b1;
            alloc_d[owner_q] = 1'b1;
            last_grant_d     = owner_q;
            state_d          = StIdle;
          end
        end
      end
      StResp: begin
        if (handshake) begin
          rvalid_d         = 1'b0;
          bvalid_d         = 1'b0;
          alloc_d[owner_q] = 1'b1;
          last_grant_d     = owner_q;
          state_d          = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= StIdle;
      owner_q      <= '0;
      last_grant_q <= IdxW'(NUM_VC - 1);
      is_read_q    <= 1'b0;
      resp_q       <= '0;
      rdata_q      <= '0;
      rresp_q      <= '0;
      bresp_q      <= '0;
      rvalid_q     <= 1'b0;
      bvalid_q     <= 1'b0;
      alloc_q      <= '1;
      on_off_q     <= '1;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      last_grant_q <= last_grant_d;
      is_read_q    <= is_read_d;
      resp_q       <= resp_d;
      rdata_q      <= rdata_d;
      rresp_q      <= rresp_d;
      bresp_q      <= bresp_d;
      rvalid_q     <= rvalid_d;
      bvalid_q     <= bvalid_d;
      alloc_q      <= alloc_d;
      on_off_q     <= ~vc_afull;
      err_q        <= err_d;
    end
  end

  assign rdata          = rdata_q;
  assign rresp          = rresp_q;
  assign rvalid         = rvalid_q;
  assign bresp          = bresp_q;
  assign bvalid         = bvalid_q;
  assign is_allocatable = alloc_q;
  assign is_on_off      = on_off_q;
  assign err_proto      = err_q;

endmodule

// File: tb/tb_mna_response_scheduler.sv
// Scoreboard bench for mna_response_scheduler with a flit-queue model of the VC buffers.
module tb_mna_response_scheduler;

  localparam int unsigned NumVc = 8;
  localparam int unsigned DataW = 32;

  logic                    clk = 1'b0;
  logic                    rst_n = 1'b0;
  logic [NumVc-1:0]        vc_valid = '0;
  logic [NumVc-1:0]        vc_head = '0;
  logic [NumVc*DataW-1:0]  vc_data = '0;
  logic [NumVc-1:0]        vc_afull = '0;
  logic [NumVc-1:0]        vc_pop;
  logic [DataW-1:0]        rdata;
  logic [1:0]              rresp;
  logic                    rvalid;
  logic                    rready = 1'b0;
  logic [1:0]              bresp;
  logic                    bvalid;
  logic                    bready = 1'b0;
  logic [NumVc-1:0]        is_allocatable;
  logic [NumVc-1:0]        is_on_off;
  logic                    err_proto;

  mna_response_scheduler #(
    .NUM_VC(NumVc),
    .DATA_W(DataW)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .vc_valid      (vc_valid),
    .vc_head       (vc_head),
    .vc_data       (vc_data),
    .vc_afull      (vc_afull),
    .vc_pop        (vc_pop),
    .rdata         (rdata),
    .rresp         (rresp),
    .rvalid        (rvalid),
    .rready        (rready),
    .bresp         (bresp),
    .bvalid        (bvalid),
    .bready        (bready),
    .is_allocatable(is_allocatable),
    .is_on_off     (is_on_off),
    .err_proto     (err_proto)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rd;
    logic [1:0]  resp;
    logic [31:0] data;
  } exp_t;

  exp_t         exp_q[$];
  logic [DataW:0] flit_q[NumVc][$];  // {is_header, flit}
  int           n_checks = 0;
  int           n_errors = 0;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic send(input int vc, input logic [31:0] hdr, input logic [31:0] body);
    flit_q[vc].push_back({1'b1, hdr});
    flit_q[vc].push_back({1'b0, body});
  endtask

  task automatic expect_rsp(input logic rd, input logic [1:0] resp, input logic [31:0] data);
    exp_t e;
    e.rd = rd;
    e.resp = resp;
    e.data = data;
    exp_q.push_back(e);
  endtask

  // Drive the head of every VC queue onto the DUT inputs.
  task automatic present();
    for (int i = 0; i < NumVc; i++) begin
      vc_valid[i] = flit_q[i].size() != 0;
      vc_head[i]  = (flit_q[i].size() != 0) ? flit_q[i][0][DataW] : 1'b0;
      vc_data[i*DataW +: DataW] = (flit_q[i].size() != 0) ? flit_q[i][0][DataW-1:0] : '0;
    end
    #1;
  endtask

  function automatic bit queues_empty();
    for (int i = 0; i < NumVc; i++) if (flit_q[i].size() != 0) return 1'b0;
    return 1'b1;
  endfunction

  // One clock: observe handshakes and pops before the edge, then update the VC model.
  task automatic tick();
    logic [NumVc-1:0] pending;
    exp_t e;
    pending = vc_pop;
    check("rb_exclusive", 32'(rvalid & bvalid), 0);
    if (rvalid && rready) begin
      check("sb_pending_r", 32'(exp_q.size() != 0), 1);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        check("r_kind", 1, 32'(e.rd));
        check("rdata", rdata, e.data);
        check("rresp", 32'(rresp), 32'(e.resp));
      end
    end
    if (bvalid && bready) begin
      check("sb_pending_b", 32'(exp_q.size() != 0), 1);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        check("b_kind", 0, 32'(e.rd));
        check("bresp", 32'(bresp), 32'(e.resp));
      end
    end
    @(posedge clk);
    #1;
    for (int i = 0; i < NumVc; i++)
      if (pending[i] && flit_q[i].size() != 0) void'(flit_q[i].pop_front());
    present();
  endtask

  task automatic wait_idle(input int budget);
    int n = 0;
    while ((exp_q.size() != 0 || !queues_empty()) && n < budget) begin
      tick();
      n++;
    end
    check("drain_in_budget", 32'(n < budget), 1);
  endtask

  initial begin
    #12;
    check("rst_rvalid", 32'(rvalid), 0);
    check("rst_bvalid", 32'(bvalid), 0);
    check("rst_rdata", rdata, 0);
    check("rst_alloc", 32'(is_allocatable), 32'hFF);
    check("rst_on_off", 32'(is_on_off), 32'hFF);
    check("rst_err", 32'(err_proto), 0);
    check("rst_pop", 32'(vc_pop), 0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Minimum-latency read on VC0.
    rready = 1'b1;
    send(0, 32'h4, 32'hDEADBEEF);
    expect_rsp(1'b1, 2'b00, 32'hDEADBEEF);
    present();
    check("c0_pop_hdr", 32'(vc_pop), 32'h01);
    tick();
    check("c1_pop_body", 32'(vc_pop), 32'h01);
    check("c1_alloc", 32'(is_allocatable), 32'hFE);
    check("c1_rvalid", 32'(rvalid), 0);
    tick();
    check("c2_rvalid", 32'(rvalid), 1);
    check("c2_rdata", rdata, 32'hDEADBEEF);
    check("c2_rresp", 32'(rresp), 0);
    tick();
    check("c3_alloc", 32'(is_allocatable), 32'hFF);
    check("c3_rvalid", 32'(rvalid), 0);

    // Write on VC3 with back-pressure on B.
    send(3, 32'h2, 32'hCAFE0000);
    expect_rsp(1'b0, 2'b10, 32'h0);
    present();
    check("w_pop_hdr", 32'(vc_pop), 32'h08);
    tick();
    tick();
    for (int k = 0; k < 5; k++) begin
      check("w_bvalid_hold", 32'(bvalid), 1);
      check("w_bresp_hold", 32'(bresp), 32'h2);
      check("w_no_r", 32'(rvalid), 0);
      check("w_alloc_hold", 32'(is_allocatable), 32'hF7);
      tick();
    end
    bready = 1'b1;
    tick();
    check("w_bvalid_drop", 32'(bvalid), 0);
    check("w_alloc_back", 32'(is_allocatable), 32'hFF);
    bready = 1'b0;

    // Prime last_grant to 5, then three simultaneous requests.
    send(5, 32'h4, 32'h50505050);
    expect_rsp(1'b1, 2'b00, 32'h50505050);
    present();
    wait_idle(50);
    send(1, 32'h4, 32'h11111111);
    send(5, 32'h5, 32'h55555555);
    send(7, 32'h6, 32'h77777777);
    expect_rsp(1'b1, 2'b10, 32'h77777777);
    expect_rsp(1'b1, 2'b00, 32'h11111111);
    expect_rsp(1'b1, 2'b01, 32'h55555555);
    present();
    check("arb_first", 32'(vc_pop), 32'h80);
    wait_idle(100);

    // Header where a body was expected on VC2.
    flit_q[2].push_back({1'b1, 32'h4});
    send(2, 32'h4, 32'h12345678);
    expect_rsp(1'b1, 2'b00, 32'h12345678);
    present();
    check("err_pop_hdr", 32'(vc_pop), 32'h04);
    tick();
    check("err_no_pop", 32'(vc_pop), 32'h00);
    tick();
    check("err_flag", 32'(err_proto), 1);
    check("err_alloc", 32'(is_allocatable), 32'hFF);
    check("err_no_rvalid", 32'(rvalid), 0);
    check("err_no_bvalid", 32'(bvalid), 0);
    wait_idle(50);
    check("err_sticky", 32'(err_proto), 1);

    // is_on_off is a registered copy of ~vc_afull.
    vc_afull = 8'h81;
    #1;
    check("onoff_lag", 32'(is_on_off), 32'hFF);
    tick();
    check("onoff_set", 32'(is_on_off), 32'h7E);

    // Asynchronous reset while a read response is pending.
    rready = 1'b0;
    send(4, 32'h4, 32'hA5A5A5A5);
    present();
    tick();
    tick();
    check("pre_rst_rvalid", 32'(rvalid), 1);
    check("pre_rst_rdata", rdata, 32'hA5A5A5A5);
    rst_n = 1'b0;
    #1;
    check("arst_rvalid", 32'(rvalid), 0);
    check("arst_rdata", rdata, 0);
    check("arst_alloc", 32'(is_allocatable), 32'hFF);
    check("arst_on_off", 32'(is_on_off), 32'hFF);
    check("arst_err", 32'(err_proto), 0);
    for (int i = 0; i < NumVc; i++) flit_q[i].delete();
    exp_q.delete();
    vc_afull = '0;
    #1;
    rst_n = 1'b1;

    // After reset VC0 wins ahead of VC6.
    rready = 1'b1;
    send(6, 32'h4, 32'h66666666);
    send(0, 32'h6, 32'h0A0A0A0A);
    expect_rsp(1'b1, 2'b10, 32'h0A0A0A0A);
    expect_rsp(1'b1, 2'b00, 32'h66666666);
    present();
    check("post_rst_first", 32'(vc_pop), 32'h01);
    wait_idle(50);
    check("sb_empty", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
